pipe_cla_addsub: RTL and testbench

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

---
 rtl/alu_pkg.sv | 36 +++
 rtl/cla_slice.sv | 32 +++
 rtl/pipe_cla_addsub.sv | 135 +++++++++++++
 tb/tb_pipe_cla_addsub.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and the 4-bit carry-lookahead group used by the pipelined add/sub.
package alu_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 2;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;
  localparam int unsigned GROUP_W    = 4;

  typedef struct packed {
    logic [GROUP_W-1:0] sum;
    logic               cout;
  } cla4_t;

  // Fully expanded lookahead carries for one 4-bit group.
  function automatic cla4_t cla4(input logic [GROUP_W-1:0] a,
                                 input logic [GROUP_W-1:0] b,
                                 input logic               cin);
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W:0]   c;
    cla4_t              r;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    r.sum  = p ^ c[GROUP_W-1:0];
    r.cout = c[GROUP_W];
    return r;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational adder slice: 4-bit lookahead groups with ripple carry between groups.
module cla_slice
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  localparam int unsigned NG = W / GROUP_W;

  logic [NG:0] w_c;
  cla4_t       w_grp;

  always_comb begin
    w_c    = '0;
    w_grp  = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int unsigned g = 0; g < NG; g++) begin
      w_grp = cla4(i_a[g*GROUP_W +: GROUP_W], i_b[g*GROUP_W +: GROUP_W], w_c[g]);
      o_sum[g*GROUP_W +: GROUP_W] = w_grp.sum;
      w_c[g+1] = w_grp.cout;
    end
    o_cout = w_c[NG];
  end

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract: one WIDTH/STAGES-bit CLA slice per stage, carry and operands
// skewed through stage registers, valid/ready handshake with collapsing bubbles.
module pipe_cla_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned SW = WIDTH / ((STAGES == 0) ? 1 : STAGES);

  generate
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || WIDTH == 0 ||
        (WIDTH % (GROUP_W * ((STAGES == 0) ? 1 : STAGES))) != 0) begin : g_bad_params
      $error("pipe_cla_addsub: illegal WIDTH/STAGES combination");
    end
  endgenerate

  logic             r_vld     [STAGES];
  logic             r_c       [STAGES];
  logic [WIDTH-1:0] r_a       [STAGES];
  logic [WIDTH-1:0] r_b       [STAGES];
  logic [WIDTH-1:0] r_res     [STAGES];

  logic             w_in_vld  [STAGES];
  logic             w_in_c    [STAGES];
  logic [WIDTH-1:0] w_in_a    [STAGES];
  logic [WIDTH-1:0] w_in_b    [STAGES];
  logic [WIDTH-1:0] w_in_res  [STAGES];
  logic [SW-1:0]    w_sum     [STAGES];
  logic             w_cout    [STAGES];
  logic [WIDTH-1:0] w_res_nxt [STAGES];
  logic             w_rdy     [STAGES];
  logic             w_ovf;
  logic             w_zero;

  // Stage inputs: stage 0 takes the port beat (B inverted for subtract), later stages the skew regs.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_in_vld[k] = 1'b0;
      w_in_c[k]   = 1'b0;
      w_in_a[k]   = '0;
      w_in_b[k]   = '0;
      w_in_res[k] = '0;
    end
    w_in_vld[0] = i_valid;
    w_in_a[0]   = i_a;
    w_in_b[0]   = i_sub ? ~i_b : i_b;
    w_in_c[0]   = i_sub;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_in_vld[k] = r_vld[k-1];
      w_in_c[k]   = r_c[k-1];
      w_in_a[k]   = r_a[k-1];
      w_in_b[k]   = r_b[k-1];
      w_in_res[k] = r_res[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_slice #(.W(SW)) u_slice (
      .i_a    (w_in_a[k][k*SW +: SW]),
      .i_b    (w_in_b[k][k*SW +: SW]),
      .i_cin  (w_in_c[k]),
      .o_sum  (w_sum[k]),
      .o_cout (w_cout[k])
    );
  end

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) w_rdy[k] = 1'b0;
    w_rdy[STAGES-1] = !r_vld[STAGES-1] || i_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) w_rdy[k] = !r_vld[k] || w_rdy[k+1];
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_res_nxt[k] = w_in_res[k];
      w_res_nxt[k][k*SW +: SW] = w_sum[k];
    end
    w_ovf  = (w_in_a[STAGES-1][WIDTH-1] == w_in_b[STAGES-1][WIDTH-1]) &&
             (w_res_nxt[STAGES-1][WIDTH-1] != w_in_a[STAGES-1][WIDTH-1]);
    w_zero = (w_res_nxt[STAGES-1] == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) r_vld[k] <= 1'b0;
      o_result <= '0;
      o_cout   <= 1'b0;
      o_ovf    <= 1'b0;
      o_zero   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) r_vld[k] <= w_in_vld[k];
      end
      if (w_rdy[STAGES-1] && w_in_vld[STAGES-1]) begin
        o_result <= w_res_nxt[STAGES-1];
        o_cout   <= w_cout[STAGES-1];
        o_ovf    <= w_ovf;
        o_zero   <= w_zero;
      end
    end
  end

  // Skew registers for intermediate stages; qualified by the valid bits, so left unreset.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k + 1 < STAGES; k++) begin
      if (w_rdy[k] && w_in_vld[k]) begin
        r_a[k]   <= w_in_a[k];
        r_b[k]   <= w_in_b[k];
        r_c[k]   <= w_cout[k];
        r_res[k] <= w_res_nxt[k];
      end
    end
  end

  assign o_valid = r_vld[STAGES-1];
  assign o_ready = w_rdy[0];

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Directed vector bench for pipe_cla_addsub (WIDTH=32, STAGES=2).
module tb_pipe_cla_addsub;

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_cout;
  logic        o_ovf;
  logic        o_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vec [12];

  pipe_cla_addsub #(.WIDTH(32), .STAGES(2)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_sub    (i_sub),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_cout   (o_cout),
    .o_ovf    (o_ovf),
    .o_zero   (o_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer vec[first..first+n-1] back-to-back; i_ready is low for cycles lo..hi (none if lo>hi).
  task automatic run_stream(input int first, input int n, input int lo, input int hi);
    int          q_idx [$];
    int          q_acc [$];
    int          cyc, sent, got, idx, acc, last_dlv;
    bit          stall_on, stalled;
    logic [31:0] s_res;
    logic        s_c, s_o, s_z;
    stall_on = (lo <= hi);
    cyc = 0; sent = 0; got = 0; last_dlv = -1; stalled = 1'b0;
    s_res = '0; s_c = 1'b0; s_o = 1'b0; s_z = 1'b0;
    while (got < n && cyc < 200) begin
      if (sent < n) begin
        i_valid = 1'b1;
        i_a     = vec[first+sent].a;
        i_b     = vec[first+sent].b;
        i_sub   = vec[first+sent].sub;
      end else begin
        i_valid = 1'b0;
      end
      i_ready = !(cyc >= lo && cyc <= hi);
      @(negedge clk);
      check("o_ready", 32'(o_ready), 32'(!(cyc >= lo && cyc <= hi)));
      if (stalled) begin
        check("hold_valid",  32'(o_valid), 32'd1);
        check("hold_result", o_result, s_res);
        check("hold_flags",  {29'd0, o_cout, o_ovf, o_zero}, {29'd0, s_c, s_o, s_z});
      end
      stalled = o_valid && !i_ready;
      if (stalled) begin
        s_res = o_result; s_c = o_cout; s_o = o_ovf; s_z = o_zero;
      end
      if (i_valid && o_ready) begin
        q_idx.push_back(first + sent);
        q_acc.push_back(cyc);
        sent++;
      end
      if (o_valid && i_ready) begin
        if (q_idx.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          idx = q_idx.pop_front();
          acc = q_acc.pop_front();
          check("result", o_result, vec[idx].res);
          check("cout", 32'(o_cout), 32'(vec[idx].cout));
          check("ovf",  32'(o_ovf),  32'(vec[idx].ovf));
          check("zero", 32'(o_zero), 32'(vec[idx].zero));
          if (!stall_on) check("latency", 32'(cyc - acc), 32'd2);
        end
        got++;
        last_dlv = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    check("beat_count", 32'(got), 32'(n));
    check("last_delivery_cycle", 32'(last_dlv), 32'(n + 1 + (stall_on ? hi - lo + 1 : 0)));
  endtask

  initial begin
    clk = 1'b0; i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_sub = 1'b0;

    //         sub   a             b             result        cout  ovf   zero
    vec[0]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vec[1]  = '{1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vec[2]  = '{1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vec[6]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vec[7]  = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vec[11] = '{1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid",  32'(o_valid), 32'd0);
    check("rst_o_ready",  32'(o_ready), 32'd1);
    check("rst_o_result", o_result, 32'd0);
    check("rst_o_flags",  {29'd0, o_cout, o_ovf, o_zero}, 32'd0);
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_stream(i, 1, 1, 0);
    run_stream(0, 12, 1, 0);
    run_stream(0, 6, 3, 5);

    // Two beats in flight, then a one-cycle reset.
    i_ready = 1'b1;
    i_valid = 1'b1; i_a = vec[6].a; i_b = vec[6].b; i_sub = vec[6].sub;
    @(posedge clk); #1;
    i_a = vec[7].a; i_b = vec[7].b; i_sub = vec[7].sub;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_o_valid",  32'(o_valid), 32'd0);
    check("mid_rst_o_ready",  32'(o_ready), 32'd1);
    check("mid_rst_o_result", o_result, 32'd0);
    check("mid_rst_o_flags",  {29'd0, o_cout, o_ovf, o_zero}, 32'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_stream(8, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
